// File: rtl/apb_pkg.sv
// Shared definitions for the APB requester bridge: state encoding, default
// widths, slave-decode bit and timeout length (timeout used only with APB_TIMEOUT_EN).
package apb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

  localparam int ADDR_W_DEF         = 8;
  localparam int DATA_W_DEF         = 8;
  localparam int SEL_BIT_DEF        = 7;
  localparam int TIMEOUT_CYCLES_DEF = 16;

  // One-hot {PSEL2, PSEL1}; all-zero when the bus is not in a transfer.
  function automatic logic [1:0] sel_onehot(input logic sel_bit, input logic active);
    logic [1:0] sel;
    if (!active) begin
      sel = 2'b00;
    end else if (sel_bit) begin
      sel = 2'b10;
    end else begin
      sel = 2'b01;
    end
    return sel;
  endfunction

endpackage

// File: rtl/apb_slave_decode.sv
// Slave select decode: selected address bit -> one-hot {PSEL2, PSEL1},
// forced to zero when no transfer is active.
module apb_slave_decode
  import apb_pkg::*;
(
  input  logic       addr_sel_i,
  input  logic       active_i,
  output logic [1:0] psel_o
);

  // Pure combinational decode; the top registers the result.
  always_comb begin
    psel_o = sel_onehot(addr_sel_i, active_i);
  end

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: single-beat command interface to SETUP/ACCESS sequences on PSEL1/PSEL2.
// Define APB_TIMEOUT_EN to abort ACCESS after TIMEOUT_CYCLES wait cycles (err pulse).
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int SEL_BIT = SEL_BIT_DEF
`ifdef APB_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
`endif
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic              transfer,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              PSEL1,
  output logic              PSEL2,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err
);

  apb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              pwrite_q, pwrite_d;
  logic [1:0]        psel_q, psel_s;
  logic              penable_q, penable_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              req_ready_s;
  logic              accept_s;
  logic              active_s;

`ifdef APB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
  logic             tmo_hit_s;

  assign tmo_hit_s = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Wait-cycle counter: zero outside ACCESS, so it restarts on every ACCESS entry.
  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if (state_q != ST_ACCESS) begin
      tmo_cnt_d = '0;
    end else if (!tmo_hit_s) begin
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
    end else begin
      tmo_cnt_d = tmo_cnt_q;
    end
  end

  // Wait-cycle counter register.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end
`endif

  // Ready depends on the live PREADY so a completing ACCESS can chain straight into SETUP.
  assign req_ready_s = (state_q == ST_IDLE) || ((state_q == ST_ACCESS) && PREADY);
  assign accept_s    = req_ready_s && transfer;

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (transfer) begin
          state_d = ST_SETUP;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETUP: begin
        state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY) begin
          done_d = 1'b1;
          if (!pwrite_q) begin
            rd_data_d  = PRDATA;
            rd_valid_d = 1'b1;
          end else begin
            rd_data_d  = rd_data_q;
            rd_valid_d = 1'b0;
          end
          if (transfer) begin
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
`ifdef APB_TIMEOUT_EN
        end else if (tmo_hit_s) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
`endif
        end else begin
          state_d = ST_ACCESS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept_s) begin
      paddr_d  = req_addr;
      pwdata_d = req_wdata;
      pwrite_d = req_write;
    end else begin
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
    end

    active_s  = (state_d != ST_IDLE);
    penable_d = (state_d == ST_ACCESS);
  end

  apb_slave_decode u_decode (
    .addr_sel_i (paddr_d[SEL_BIT]),
    .active_i   (active_s),
    .psel_o     (psel_s)
  );

  // State and registered bus/requester outputs.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= ST_IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      psel_q     <= 2'b00;
      penable_q  <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      psel_q     <= psel_s;
      penable_q  <= penable_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign req_ready = req_ready_s;
  assign PSEL1     = psel_q[0];
  assign PSEL2     = psel_q[1];
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_master_bridge;

  localparam int TMO = 16;

  logic       PCLK = 1'b0;
  logic       PRESET;
  logic       transfer;
  logic       req_write;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready;
  logic       PSEL1;
  logic       PSEL2;
  logic       PENABLE;
  logic       PWRITE;
  logic [7:0] PADDR;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       done;
  logic       err;

  int checks = 0;
  int errors = 0;

  apb_master_bridge dut (
    .PCLK      (PCLK),
    .PRESET    (PRESET),
    .transfer  (transfer),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_ready (req_ready),
    .PSEL1     (PSEL1),
    .PSEL2     (PSEL2),
    .PENABLE   (PENABLE),
    .PWRITE    (PWRITE),
    .PADDR     (PADDR),
    .PWDATA    (PWDATA),
    .PRDATA    (PRDATA),
    .PREADY    (PREADY),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .done      (done),
    .err       (err)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: one outstanding transaction, m_acc = 0 in its setup cycle, k in its k-th access cycle.
  bit         m_known = 1'b0;
  bit         m_busy;
  int         m_acc;
  logic [7:0] m_addr;
  logic [7:0] m_wdata;
  logic       m_write;
  logic [7:0] m_rd;
  bit         m_done;
  bit         m_rdv;
  bit         m_err;
  bit         m_take;

  function automatic bit m_ready();
    return !m_busy || (m_acc >= 1 && PREADY === 1'b1);
  endfunction

  always @(posedge PCLK) begin
    if (PRESET) begin
      m_known = 1'b1;
      m_busy = 1'b0; m_acc = 0;
      m_addr = 8'h00; m_wdata = 8'h00; m_write = 1'b0; m_rd = 8'h00;
      m_done = 1'b0; m_rdv = 1'b0; m_err = 1'b0;
    end else if (m_known) begin
      m_take = m_ready() && (transfer === 1'b1);
      m_done = 1'b0; m_rdv = 1'b0; m_err = 1'b0;
      if (m_busy && m_acc >= 1 && PREADY === 1'b1) begin
        m_done = 1'b1;
        if (!m_write) begin
          m_rd  = PRDATA;
          m_rdv = 1'b1;
        end
        m_busy = 1'b0;
      end
`ifdef APB_TIMEOUT_EN
      else if (m_busy && m_acc == TMO) begin
        m_err  = 1'b1;
        m_busy = 1'b0;
      end
`endif
      else if (m_busy) begin
        m_acc++;
      end
      if (m_take) begin
        m_busy = 1'b1; m_acc = 0;
        m_addr = req_addr; m_wdata = req_wdata; m_write = req_write;
      end
    end
  end

  always @(negedge PCLK) begin
    #1;
    if (m_known) begin
      chk("m_psel1",     PSEL1,     m_busy && !m_addr[7]);
      chk("m_psel2",     PSEL2,     m_busy && m_addr[7]);
      chk("m_penable",   PENABLE,   m_busy && m_acc >= 1);
      chk("m_pwrite",    PWRITE,    m_write);
      chk("m_paddr",     PADDR,     m_addr);
      chk("m_pwdata",    PWDATA,    m_wdata);
      chk("m_rd_data",   rd_data,   m_rd);
      chk("m_rd_valid",  rd_valid,  m_rdv);
      chk("m_done",      done,      m_done);
      chk("m_err",       err,       m_err);
      chk("m_req_ready", req_ready, m_ready());
    end
  end

  task automatic tick();
    @(negedge PCLK);
  endtask

  int n;
  bit seen_err;
  int quiet;

  initial begin
    PRESET = 1'b1; transfer = 1'b0; req_write = 1'b0; req_addr = 8'h00; req_wdata = 8'h00;
    PRDATA = 8'h00; PREADY = 1'b0;
    tick(); tick();
    #2;
    chk("rst_psel1", PSEL1, 1'b0);
    chk("rst_penable", PENABLE, 1'b0);
    chk("rst_rd_data", rd_data, 8'h00);
    chk("rst_req_ready", req_ready, 1'b1);

    // Write 0xA5 to 0x05 on slave 1.
    tick();
    PRESET = 1'b0; transfer = 1'b1; req_write = 1'b1; req_addr = 8'h05; req_wdata = 8'hA5;
    tick();
    transfer = 1'b0;
    #2;
    chk("wr_setup_psel1", PSEL1, 1'b1);
    chk("wr_setup_psel2", PSEL2, 1'b0);
    chk("wr_setup_penable", PENABLE, 1'b0);
    chk("wr_setup_paddr", PADDR, 8'h05);
    chk("wr_setup_ready", req_ready, 1'b0);
    tick();
    PREADY = 1'b1;
    #2;
    chk("wr_access_penable", PENABLE, 1'b1);
    chk("wr_access_pwdata", PWDATA, 8'hA5);
    chk("wr_access_ready", req_ready, 1'b1);
    tick();
    PREADY = 1'b0;
    #2;
    chk("wr_done", done, 1'b1);
    chk("wr_done_psel1", PSEL1, 1'b0);
    chk("wr_done_rdv", rd_valid, 1'b0);
    chk("wr_paddr_held", PADDR, 8'h05);

    // Read 0x85 on slave 2, PRDATA = 0x3C.
    transfer = 1'b1; req_write = 1'b0; req_addr = 8'h85;
    tick();
    transfer = 1'b0;
    #2;
    chk("rd_setup_psel2", PSEL2, 1'b1);
    chk("rd_setup_psel1", PSEL1, 1'b0);
    chk("rd_setup_pwrite", PWRITE, 1'b0);
    tick();
    PREADY = 1'b1; PRDATA = 8'h3C;
    tick();
    PREADY = 1'b0; PRDATA = 8'h00;
    #2;
    chk("rd_data", rd_data, 8'h3C);
    chk("rd_valid", rd_valid, 1'b1);
    chk("rd_done", done, 1'b1);
    tick();
    #2;
    chk("rd_valid_drop", rd_valid, 1'b0);
    chk("rd_data_held", rd_data, 8'h3C);

    // Three wait states: ACCESS lasts four cycles.
    transfer = 1'b1; req_write = 1'b1; req_addr = 8'h22; req_wdata = 8'h5A;
    tick();
    transfer = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) PREADY = 1'b1;
      #2;
      chk("ws_penable", PENABLE, 1'b1);
      chk("ws_paddr", PADDR, 8'h22);
      chk("ws_pwdata", PWDATA, 8'h5A);
      chk("ws_ready", req_ready, (i == 4) ? 1'b1 : 1'b0);
      chk("ws_done", done, 1'b0);
    end
    tick();
    PREADY = 1'b0;
    #2;
    chk("ws_done_end", done, 1'b1);

    // Back-to-back write 0x10 then read 0x11 with transfer held high.
    transfer = 1'b1; req_write = 1'b1; req_addr = 8'h10; req_wdata = 8'h77;
    tick();
    req_write = 1'b0; req_addr = 8'h11;
    tick();
    PREADY = 1'b1;
    tick();
    transfer = 1'b0; PRDATA = 8'hC3;
    #2;
    chk("b2b_done", done, 1'b1);
    chk("b2b_setup_penable", PENABLE, 1'b0);
    chk("b2b_setup_psel1", PSEL1, 1'b1);
    chk("b2b_paddr", PADDR, 8'h11);
    chk("b2b_pwrite", PWRITE, 1'b0);
    tick();
    tick();
    PREADY = 1'b0;
    #2;
    chk("b2b_rd_data", rd_data, 8'hC3);
    chk("b2b_rd_valid", rd_valid, 1'b1);

    // Reset in the middle of ACCESS.
    transfer = 1'b1; req_write = 1'b0; req_addr = 8'h90;
    tick();
    transfer = 1'b0;
    tick();
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;
    #2;
    chk("mid_rst_psel2", PSEL2, 1'b0);
    chk("mid_rst_penable", PENABLE, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_rd_data", rd_data, 8'h00);

    // PREADY held low for a long ACCESS.
    transfer = 1'b1; req_write = 1'b0; req_addr = 8'h40;
    tick();
    transfer = 1'b0;
    n = 0; seen_err = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      #2;
      if (err) begin
        seen_err = 1'b1;
        break;
      end
      if (PENABLE) n++;
    end
`ifdef APB_TIMEOUT_EN
    chk("tmo_err_seen", seen_err, 1'b1);
    chk("tmo_access_cycles", n, TMO);
    chk("tmo_penable", PENABLE, 1'b0);
    chk("tmo_rd_data", rd_data, 8'h00);
`else
    chk("no_tmo_err", seen_err, 1'b0);
    chk("no_tmo_cycles", n, 100);
    chk("no_tmo_penable", PENABLE, 1'b1);
`endif
    PRESET = 1'b1;
    tick();
    PRESET = 1'b0;

    // Randomized traffic with occasional long PREADY-low bursts and resets.
    quiet = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      PRESET    = ($urandom_range(0, 299) == 0);
      transfer  = ($urandom_range(0, 2) != 0);
      req_write = $urandom_range(0, 1) != 0;
      req_addr  = 8'($urandom_range(0, 255));
      req_wdata = 8'($urandom_range(0, 255));
      PRDATA    = 8'($urandom_range(0, 255));
      if (quiet > 0) begin
        PREADY = 1'b0;
        quiet--;
      end else begin
        PREADY = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 149) == 0) quiet = 20;
      end
    end
    PRESET = 1'b0; transfer = 1'b0;
    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
